// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs fields into a 32-bit word, range-checks the immediate,
// and tags each word with a sequential address behind a one-word valid/ready output register.
module instruction_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [6:0]        op_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       Instruction_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [1:0]        err_o,
    output logic [7:0]        err_cnt_o
);

    localparam logic [6:0]  OP_R    = 7'b0110011;
    localparam logic [6:0]  OP_I    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [6:0]  OP_S    = 7'b0100011;
    localparam logic [6:0]  OP_B    = 7'b1100011;
    localparam logic [6:0]  OP_U    = 7'b0110111;
    localparam logic [6:0]  OP_J    = 7'b1101111;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [1:0]  ERR_OK  = 2'b00;
    localparam logic [1:0]  ERR_IMM = 2'b01;
    localparam logic [1:0]  ERR_OP  = 2'b10;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [31:0]       enc_word;
    logic [1:0]        enc_err;
    logic              accept;

    logic              valid_q,   valid_d;
    logic [31:0]       instr_q,   instr_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [1:0]        err_q,     err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] ptr_q,     ptr_d;

    // Field packing and immediate range check; out-of-range words still use the truncated bits.
    always_comb begin
        enc_word = NOP;
        enc_err  = ERR_OK;
        unique case (op_i)
            OP_R: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
            OP_I, OP_LOAD, OP_JALR: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                if (imm_i[31:11] != {21{imm_i[31]}}) enc_err = ERR_IMM;
            end
            OP_S: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
                if (imm_i[31:11] != {21{imm_i[31]}}) enc_err = ERR_IMM;
            end
            OP_B: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], op_i};
                if (imm_i[31:12] != {20{imm_i[31]}} || imm_i[0]) enc_err = ERR_IMM;
            end
            OP_U: begin
                enc_word = {imm_i[31:12], rd_i, op_i};
                if (imm_i[11:0] != 12'd0) enc_err = ERR_IMM;
            end
            OP_J: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                if (imm_i[31:20] != {12{imm_i[31]}} || imm_i[0]) enc_err = ERR_IMM;
            end
            default: begin
                enc_word = NOP;
                enc_err  = ERR_OP;
            end
        endcase
    end

    assign ready_o = !clear_i && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;

    // Output register, address pointer and error counter; clear wins over everything.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        ptr_d     = ptr_q;
        if (clear_i) begin
            valid_d   = 1'b0;
            ptr_d     = BASE;
            err_cnt_d = 8'd0;
        end else if (accept) begin
            valid_d = 1'b1;
            instr_d = enc_word;
            err_d   = enc_err;
            addr_d  = ptr_q;
            ptr_d   = ptr_q + ADDR_W'(1);
            if (enc_err != ERR_OK && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            instr_q   <= 32'd0;
            addr_q    <= BASE;
            err_q     <= ERR_OK;
            err_cnt_q <= 8'd0;
            ptr_q     <= BASE;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign valid_o       = valid_q;
    assign Instruction_o = instr_q;
    assign addr_o        = addr_q;
    assign err_o         = err_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed vector table, hand-written multi-cycle sequences,
// and a randomized stream scored against an arithmetic reference model.
module tb_instruction_encoder;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned BASE_ADDR = 0;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear_i;
    logic              valid_i;
    logic              ready_o;
    logic [6:0]        op_i;
    logic [4:0]        rd_i, rs1_i, rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [31:0]       imm_i;
    logic              valid_o;
    logic              ready_i;
    logic [31:0]       Instruction_o;
    logic [ADDR_W-1:0] addr_o;
    logic [1:0]        err_o;
    logic [7:0]        err_cnt_o;

    instruction_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .imm_i(imm_i), .valid_o(valid_o), .ready_i(ready_i),
        .Instruction_o(Instruction_o), .addr_o(addr_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       word;
        logic [1:0]        err;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    typedef struct {
        logic              clr;
        logic [6:0]        op;
        logic [4:0]        rd, rs1, rs2;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [31:0]       imm;
        logic [31:0]       exp_word;
        logic [1:0]        exp_err;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        q[$];
    int unsigned ptr = BASE_ADDR;
    int unsigned cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned fld(input logic [31:0] v, input int hi, input int lo);
        longint unsigned vv = 64'(v);
        return (vv >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
    endfunction

    // Reference: bit placement by arithmetic, range checks on the signed value.
    function automatic void model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] imm, output logic [31:0] w, output logic [1:0] e);
        longint          s = longint'($signed(imm));
        longint unsigned o = 64'(op), d = 64'(rd), a = 64'(rs1), b = 64'(rs2);
        longint unsigned f = 64'(f3), g = 64'(f7), sum;
        e = 2'd0;
        case (op)
            7'h33: sum = o + (d << 7) + (f << 12) + (a << 15) + (b << 20) + (g << 25);
            7'h13, 7'h03, 7'h67: begin
                sum = o + (d << 7) + (f << 12) + (a << 15) + (fld(imm, 11, 0) << 20);
                if (s < -2048 || s > 2047) e = 2'd1;
            end
            7'h23: begin
                sum = o + (fld(imm, 4, 0) << 7) + (f << 12) + (a << 15) + (b << 20)
                    + (fld(imm, 11, 5) << 25);
                if (s < -2048 || s > 2047) e = 2'd1;
            end
            7'h63: begin
                sum = o + (fld(imm, 11, 11) << 7) + (fld(imm, 4, 1) << 8) + (f << 12) + (a << 15)
                    + (b << 20) + (fld(imm, 10, 5) << 25) + (fld(imm, 12, 12) << 31);
                if (s < -4096 || s > 4095 || (s % 2) != 0) e = 2'd1;
            end
            7'h37: begin
                sum = o + (d << 7) + (fld(imm, 31, 12) << 12);
                if ((64'(imm) % 4096) != 0) e = 2'd1;
            end
            7'h6F: begin
                sum = o + (d << 7) + (fld(imm, 19, 12) << 12) + (fld(imm, 11, 11) << 20)
                    + (fld(imm, 10, 1) << 21) + (fld(imm, 20, 20) << 31);
                if (s < -1048576 || s > 1048575 || (s % 2) != 0) e = 2'd1;
            end
            default: begin
                sum = 64'h13;
                e   = 2'd2;
            end
        endcase
        w = 32'(sum);
    endfunction

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
    endtask

    // One clock: score outputs against the queue, advance the model, cross the edge.
    task automatic tick();
        logic [31:0] w;
        logic [1:0]  e;
        logic        mready;
        #1;
        mready = !clear_i && (q.size() == 0 || ready_i);
        check("ready_o", 32'(ready_o), 32'(mready));
        check("valid_o", 32'(valid_o), 32'(q.size() != 0));
        check("err_cnt_o", 32'(err_cnt_o), cnt);
        if (q.size() != 0) begin
            check("word", Instruction_o, q[0].word);
            check("addr", 32'(addr_o), 32'(q[0].addr));
            check("err", 32'(err_o), 32'(q[0].err));
        end
        if (clear_i) begin
            q.delete();
            ptr = BASE_ADDR;
            cnt = 0;
        end else begin
            if (q.size() != 0 && ready_i) void'(q.pop_front());
            if (valid_i && mready) begin
                model(op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, w, e);
                q.push_back('{word: w, err: e, addr: ADDR_W'(ptr)});
                ptr = (ptr + 1) % (1 << ADDR_W);
                if (e != 2'd0 && cnt < 255) cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6F};
        logic [31:0] imm;
        case ($urandom_range(0, 3))
            0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       imm = $urandom;
            2:       imm = $urandom & 32'hFFFF_F000;
            default: imm = 32'($urandom_range(0, 4194303)) - 32'h0020_0000;
        endcase
        drive(($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 7)] : 7'($urandom),
              5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
    endtask

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h0050_0093, 2'd0, 8'd0};
        tbl[1] = '{1'b1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020_A423, 2'd0, 8'd0};
        tbl[2] = '{1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC,  32'hFE20_8EE3, 2'd0, 8'd1};
        tbl[3] = '{1'b0, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800,  32'h0010_00EF, 2'd0, 8'd2};
        tbl[4] = '{1'b0, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h1234_52B7, 2'd0, 8'd3};
        tbl[5] = '{1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h8000_0093, 2'd1, 8'd4};
        tbl[6] = '{1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,          32'h0020_8163, 2'd1, 8'd5};
        tbl[7] = '{1'b0, 7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'd0,          32'h0000_0013, 2'd2, 8'd6};
        tbl[8] = '{1'b0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         32'h4020_81B3, 2'd0, 8'd7};

        reset = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        drive(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_word", Instruction_o, 32'd0);
        check("rst_addr", 32'(addr_o), BASE_ADDR);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_cnt", 32'(err_cnt_o), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, one per cycle with ready_i high.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].clr) begin
                valid_i = 1'b0; clear_i = 1'b1;
                tick();
                clear_i = 1'b0;
            end
            drive(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm);
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
            check("tbl_valid", 32'(valid_o), 32'd1);
            check("tbl_word", Instruction_o, tbl[i].exp_word);
            check("tbl_err", 32'(err_o), 32'(tbl[i].exp_err));
            check("tbl_addr", 32'(addr_o), 32'(tbl[i].exp_addr));
        end
        check("tbl_err_cnt", 32'(err_cnt_o), 32'd3);
        tick();

        // Backpressure: first word held while second waits, then both drain in order.
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        ready_i = 1'b0;
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        valid_i = 1'b1;
        tick();
        drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 32'(ready_o), 32'd0);
            check("bp_hold_word", Instruction_o, 32'h0050_0093);
            check("bp_hold_addr", 32'(addr_o), 32'd0);
            tick();
        end
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("bp_second_word", Instruction_o, 32'h0020_A423);
        check("bp_second_addr", 32'(addr_o), 32'd1);
        tick();
        check("bp_drained", 32'(valid_o), 32'd0);

        // Address wrap over 257 words.
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 257; i++) begin
            drive(7'h13, 5'($urandom), 5'($urandom), 5'd0, 3'($urandom), 7'd0,
                  32'($urandom_range(0, 4095)) - 32'd2048);
            tick();
            if (i == 255) check("wrap_255", 32'(addr_o), 32'd255);
            if (i == 256) check("wrap_0", 32'(addr_o), 32'd0);
        end

        // Clear together with valid_i: nothing accepted, counters restart.
        drive(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        clear_i = 1'b1;
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        clear_i = 1'b0;
        check("clr_valid", 32'(valid_o), 32'd0);
        check("clr_cnt", 32'(err_cnt_o), 32'd0);
        tick();
        valid_i = 1'b0;
        check("clr_next_addr", 32'(addr_o), 32'd0);

        // Randomized stream with occasional clears.
        for (int i = 0; i < 600; i++) begin
            rand_fields();
            valid_i = 1'($urandom_range(0, 3) != 0);
            ready_i = 1'($urandom_range(0, 2) != 0);
            clear_i = 1'($urandom_range(0, 59) == 0);
            tick();
        end
        clear_i = 1'b0;

        // Asynchronous reset while a word is stalled at the output.
        ready_i = 1'b0;
        valid_i = 1'b1;
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        valid_i = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_word", Instruction_o, 32'd0);
        check("mid_rst_addr", 32'(addr_o), BASE_ADDR);
        check("mid_rst_err", 32'(err_o), 32'd0);
        check("mid_rst_cnt", 32'(err_cnt_o), 32'd0);
        q.delete();
        ptr = BASE_ADDR;
        cnt = 0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        valid_i = 1'b1;
        drive(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        tick();
        valid_i = 1'b0;
        check("post_rst_addr", 32'(addr_o), BASE_ADDR);
        check("post_rst_word", Instruction_o, 32'hFE20_8EE3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
